// File: rtl/moore_sched_pkg.sv
// Shared types for moore_seq_sched.
//   sched_state_t : scheduler FSM state encoding
//   DEFAULT_WIDTH : default job word width
package moore_sched_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    TAIL  = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/moore_seq_sched_rr_arb2.sv
// Two-way round-robin arbiter (purely combinational).
//   valid[1:0] : request lines
//   ptr        : 0 favours requester 0, 1 favours requester 1
//   grant[1:0] : one-hot grant (all zero when no request)
// The pointer register lives in the parent.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (ptr) begin
      grant[1] = valid[1];
      grant[0] = valid[0] & ~valid[1];
    end else begin
      grant[0] = valid[0];
      grant[1] = valid[1] & ~valid[0];
    end
  end

endmodule

// File: rtl/moore_seq_sched.sv
// Shares one Moore sequence-recognizer between two requesters. A granted
// word is fed MSB-first into the recognizer after a one-cycle clear, and the
// 2-bit output after each bit is packed into a 2*WIDTH trace (first bit in
// the MSBs) returned on a valid/ready response channel.
//   clk, rst                   : clock, async active-high reset
//   req0_*/req1_*              : requester valid/data/ready handshakes
//   rsp_valid/ready/id/data    : response channel (trace + owner id)
//   fsm_rst_n, fsm_in, fsm_out : recognizer reset, serial input, Moore output
//   busy                       : high whenever not IDLE
module moore_seq_sched
  import moore_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_data,
  output logic                 req1_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 fsm_rst_n,
  output logic                 fsm_in,
  input  logic [1:0]           fsm_out,
  output logic                 busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sched_state_t       state, state_n;
  logic               ptr;
  logic [WIDTH-1:0]   sr;
  logic [CW-1:0]      cnt;
  logic [1:0]         grant;
  logic [1:0]         ready;
  logic               accept;

  rr_arb2 u_arb (
    .valid (({req1_valid, req0_valid})),
    .ptr   (ptr),
    .grant (grant)
  );

  // Readies are forced low while reset is asserted, not just after it.
  assign ready      = grant & {2{(state == IDLE) & ~rst}};
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign accept     = |ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = CLEAR;
      CLEAR:   state_n = SHIFT;
      SHIFT:   if (cnt == LAST_BIT) state_n = TAIL;
      TAIL:    state_n = DONE;
      DONE:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    fsm_rst_n = 1'b1;
    fsm_in    = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      CLEAR:   fsm_rst_n = 1'b0;
      SHIFT:   fsm_in    = sr[WIDTH-1];
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Recognizer output lags its input by one cycle, so the first SHIFT edge
  // has nothing to capture and TAIL picks up the last bit's output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      sr       <= '0;
      cnt      <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sr     <= grant[1] ? req1_data : req0_data;
            rsp_id <= grant[1];
            ptr    <= ~grant[1];
          end
        end
        CLEAR: cnt <= '0;
        SHIFT: begin
          sr  <= {sr[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt != '0) rsp_data <= {rsp_data[2*WIDTH-3:0], fsm_out};
        end
        TAIL:    rsp_data <= {rsp_data[2*WIDTH-3:0], fsm_out};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_moore_seq_sched.sv
module tb_moore_seq_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;
  logic        fsm_rst_n, fsm_in, busy;
  logic [1:0]  fsm_out;
  logic        stub_q;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  moore_seq_sched #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .fsm_rst_n  (fsm_rst_n),
    .fsm_in     (fsm_in),
    .fsm_out    (fsm_out),
    .busy       (busy)
  );

  // Stub recognizer: output = {0, registered input}, synchronous clear.
  always_ff @(posedge clk) begin
    if (!fsm_rst_n) stub_q <= 1'b0;
    else            stub_q <= fsm_in;
  end
  assign fsm_out = {1'b0, stub_q};

  typedef struct {
    logic        id;
    logic [7:0]  word;
    logic [15:0] trace;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else             n_pass++;
  endtask

  // Full job from one requester, checking handshake, clear pulse, bit
  // stream, response latency and contents.
  task automatic run_job(input logic id, input logic [7:0] word, input logic [15:0] exp);
    logic [7:0]  bits;
    int unsigned n;
    bits = '0;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_data = word; end
    else    begin req0_valid = 1'b1; req0_data = word; end
    #1;
    chk("ready_now",   32'(id ? req1_ready : req0_ready), 32'd1);
    chk("other_ready", 32'(id ? req0_ready : req1_ready), 32'd0);
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = ~word; req1_data = ~word;
    #1;
    chk("clear_rst_n", 32'(fsm_rst_n), 32'd0);
    chk("busy_job",    32'(busy), 32'd1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk); #1;
      bits[7-j] = fsm_in;
      if (j == 0) chk("rst_n_released", 32'(fsm_rst_n), 32'd1);
    end
    chk("fsm_in_seq", 32'(bits), 32'(word));
    @(negedge clk); #1;
    chk("valid_early", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data",  32'(rsp_data), 32'(exp));
    chk("rsp_id",    32'(rsp_id), 32'(id));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[6];
    int unsigned grants, dbl, n;
    logic [2:0]  order;
    logic        prev, cur, seen;
    logic [15:0] held_data;
    logic        held_id;

    vecs[0] = '{1'b0, 8'b01010011, 16'h1105};
    vecs[1] = '{1'b1, 8'hFF,       16'h5555};
    vecs[2] = '{1'b0, 8'h00,       16'h0000};
    vecs[3] = '{1'b1, 8'h80,       16'h4000};
    vecs[4] = '{1'b0, 8'h01,       16'h0001};
    vecs[5] = '{1'b1, 8'hA5,       16'h4411};

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h00; req1_data = 8'h00;
    rsp_ready = 1'b0;
    #3;
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id), 32'd0);
    chk("rst_fsm_in",    32'(fsm_in), 32'd0);
    chk("rst_fsm_rst_n", 32'(fsm_rst_n), 32'd1);
    chk("rst_readys",    32'({req1_ready, req0_ready}), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Round robin with both requesters held valid from reset.
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    grants = 0; dbl = 0; prev = 1'b0; order = '0;
    for (int c = 0; c < 200 && grants < 3; c++) begin
      #1;
      cur = req0_ready | req1_ready;
      if (req0_ready && req1_ready) dbl++;
      if (cur && prev) dbl++;
      if (cur) begin order[grants] = req1_ready; grants++; end
      prev = cur;
      if (grants < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_grants", 32'(grants), 32'd3);
    chk("rr_order",  32'(order), 32'b010);
    chk("rr_pulses", 32'(dbl), 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 50);
    chk("rr_drain", 32'(busy), 32'd0);
    rsp_ready = 1'b0;

    for (int i = 0; i < 6; i++) run_job(vecs[i].id, vecs[i].word, vecs[i].trace);

    // Response stall: outputs held, no grants while waiting.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hC3;
    n = 0;
    #1;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    #1;
    chk("stall_valid", 32'(rsp_valid), 32'd1);
    chk("stall_data",  32'(rsp_data), 32'h5005);
    held_data = rsp_data; held_id = rsp_id;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("stall_hold_valid", 32'(rsp_valid), 32'd1);
      chk("stall_hold_data",  32'(rsp_data), 32'(held_data));
      chk("stall_hold_id",    32'(rsp_id), 32'(held_id));
      chk("stall_readys",     32'({req1_ready, req0_ready}), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("handshake_readys", 32'({req1_ready, req0_ready}), 32'd0);
    @(posedge clk); #1;
    chk("idle_after_hs", 32'(busy), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0;

    // Reset in the middle of SHIFT bit 3.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hFF;
    n = 0;
    #1;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_fsm_in", 32'(fsm_in), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_busy",      32'(busy), 32'd0);
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_fsm_in",    32'(fsm_in), 32'd0);
    chk("async_fsm_rst_n", 32'(fsm_rst_n), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    chk("dropped_job", 32'(seen), 32'd0);

    // Pointer favours req0 after reset; req1 alone must win immediately.
    run_job(1'b1, 8'h96, 16'h4114);
    run_job(1'b0, 8'h69, 16'h1441);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/moore_seq_sched.md
# moore_seq_sched

Job scheduler that shares one Moore sequence-recognizer FSM between two requesters. It accepts a WIDTH-bit input word from either requester via a valid/ready handshake, chosen by round-robin. It clears the FSM, then feeds the word to the FSM's serial `in` MSB-first, one bit per cycle. It collects the FSM's 2-bit Moore output after every bit and returns the packed trace to the host on a valid/ready response channel.

## Interface
- WIDTH, 8, bits per job word (≥2); response is 2*WIDTH bits
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a word
- req0_data  in  WIDTH  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle when high with valid
- req1_valid / req1_data / req1_ready  same as requester 0, for requester 1
- rsp_valid  out  1  response trace available
- rsp_ready  in  1  host takes response
- rsp_id  out  1  requester that owns the response
- rsp_data  out  2*WIDTH  FSM output trace, first bit's output in MSBs
- fsm_rst_n  out  1  active-low reset to the FSM
- fsm_in  out  1  serial bit to the FSM
- fsm_out  in  2  FSM Moore output
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, CLEAR, SHIFT, TAIL, DONE.
- IDLE: round-robin grant.
  - Only one valid: grant it.
  - Both valid: grant the one not served last. Priority pointer resets to favour req0.
  - reqN_ready is high only for the granted requester, and only in IDLE. It is combinational from valids, pointer and state.
  - On valid&ready: latch data into the shift register and id into rsp_id, flip pointer past the winner, go to CLEAR.
- CLEAR: one cycle, fsm_rst_n=0, then go to SHIFT with bit counter 0.
- SHIFT: WIDTH cycles.
  - fsm_in = shift-register MSB; shift left each cycle.
  - From the second SHIFT cycle on, capture fsm_out each edge: result ← {result[2W-3:0], fsm_out}.
  - After the last bit, go to TAIL.
- TAIL: one cycle; capture the final fsm_out, then go to DONE. Total captures = WIDTH.
- DONE: rsp_valid=1. rsp_data and rsp_id are held stable. On rsp_valid&rsp_ready, go to IDLE. No grant in that same cycle.
- Default drives outside the listed states: fsm_in=0, fsm_rst_n=1.
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, fsm_in 0, fsm_rst_n 1, busy 0, both readys 0 while rst high, pointer → req0.
- rst mid-job: the job is dropped immediately (asynchronous) and no response is issued. The next job gets CLEAR before use.

## Timing
- Acceptance edge = E.
  - fsm_rst_n low during E..E+1.
  - Bit j is driven during cycle E+1+j.
  - The FSM registers bit j at E+2+j; its output is captured at E+3+j.
  - rsp_valid rises at E+WIDTH+2.
- Minimum job-to-job spacing: WIDTH+3 cycles plus response wait.
- Requesters may change data freely after their ready handshake.

## Structure
- Package moore_sched_pkg: state typedef enum (3-bit: IDLE, CLEAR, SHIFT, TAIL, DONE) and the default WIDTH localparam.
- Sub-module rr_arb2: 2-way round-robin arbiter. Inputs: valids, pointer. Outputs: one-hot grant. The pointer update is owned by the parent.

## Test plan
Use a stub FSM: out = {1'b0, registered in}, synchronously cleared when fsm_rst_n=0. WIDTH=8.
- req0 word 8'b01010011 → fsm_in = 0,1,0,1,0,0,1,1 in cycles E+1..E+8; rsp_data = 16'h1105, rsp_id = 0, rsp_valid at E+10.
- req1 word 8'hFF → rsp_data = 16'h5555, rsp_id = 1; fsm_rst_n low for exactly one cycle, starting at E.
- Both valid out of reset, held → grants in order req0, req1, req0; each ready is a single-cycle pulse.
- rsp_ready held low 5 cycles in DONE → rsp_valid, rsp_data and rsp_id stable; both readys 0; IDLE follows the handshake cycle.
- rst pulsed during SHIFT bit 3 → busy, rsp_valid, fsm_in are 0 without waiting for a clock edge; no response; next job's trace is correct.
- Only req1 valid while the pointer favours req0 → req1 granted with no lost cycle.
